// File: rtl/ncl_dualrail_rx.sv
// Clocked consumer for an NCL dual-rail pipeline: completes DATA/NULL handshakes via ko
// and presents each decoded DATA wavefront on a valid/ready port. Optional NCL_RX_ERRCHK_EN adds a sticky illegal-code flag.
module ncl_dualrail_rx #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             init,
    input  logic [WIDTH-1:0] rail1,
    input  logic [WIDTH-1:0] rail0,
    output logic             ko,
    output logic [WIDTH-1:0] out_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    typedef enum logic {
        WAIT_DATA = 1'b0,
        WAIT_NULL = 1'b1
    } state_t;

    logic [WIDTH-1:0] dig_data;
    logic [WIDTH-1:0] dig_null;
    logic             all_data;
    logic             all_null;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_detect
            assign dig_data[gi] = rail1[gi] ^ rail0[gi];
            assign dig_null[gi] = ~(rail1[gi] | rail0[gi]);
        end
    endgenerate

    assign all_data = &dig_data;
    assign all_null = &dig_null;

    // Only the completion flags cross into this domain; the rails themselves are
    // held stable by the NCL handshake until ko rises, so they are sampled directly.
    logic [1:0] data_sync_q;
    logic [1:0] null_sync_q;
    logic       data_s;
    logic       null_s;

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            data_sync_q <= 2'b00;
            null_sync_q <= 2'b00;
        end else begin
            data_sync_q <= {data_sync_q[0], all_data};
            null_sync_q <= {null_sync_q[0], all_null};
        end
    end

    assign data_s = data_sync_q[1];
    assign null_s = null_sync_q[1];

    state_t           state_q, state_d;
    logic             ko_q, ko_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_word_q, out_word_d;
    logic             buf_free;
    logic             capture;

    assign buf_free = ~out_valid_q | out_ready;

    always_comb begin
        state_d     = state_q;
        ko_d        = ko_q;
        capture     = 1'b0;
        case (state_q)
            WAIT_DATA: begin
                // Withholding ko while the buffer is full back-pressures upstream.
                if (data_s && buf_free) begin
                    capture = 1'b1;
                    state_d = WAIT_NULL;
                    ko_d    = 1'b1;
                end
            end
            WAIT_NULL: begin
                if (null_s) begin
                    state_d = WAIT_DATA;
                    ko_d    = 1'b0;
                end
            end
            default: begin
                state_d = WAIT_DATA;
                ko_d    = 1'b0;
            end
        endcase

        out_word_d  = out_word_q;
        out_valid_d = out_valid_q;
        if (capture) begin
            out_word_d  = rail1;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q     <= WAIT_DATA;
            ko_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
        end else begin
            state_q     <= state_d;
            ko_q        <= ko_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
        end
    end

    assign ko        = ko_q;
    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;

`ifdef NCL_RX_ERRCHK_EN
    logic [WIDTH-1:0] dig_illegal;
    logic             any_illegal;
    logic [1:0]       illegal_sync_q;
    logic             err_q;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_illegal
            assign dig_illegal[gi] = rail1[gi] & rail0[gi];
        end
    endgenerate

    assign any_illegal = |dig_illegal;

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            illegal_sync_q <= 2'b00;
            err_q          <= 1'b0;
        end else begin
            illegal_sync_q <= {illegal_sync_q[0], any_illegal};
            err_q          <= err_q | illegal_sync_q[1];
        end
    end

    // Flag is visible as soon as the synchronized pulse appears, then held by err_q.
    assign err = err_q | illegal_sync_q[1];
`else
    assign err = 1'b0;
`endif

endmodule
